// File: rtl/frame_uart_streamer.sv
// frame_uart_streamer: drains the output FIFO and sends one frame over an 8N1 UART.
// Frame on the line: 0xA5, 0x5A, FRAME_LEN payload bytes, then an optional XOR checksum.
// Optional feature macro: FRAME_UART_CSUM_EN (defined -> checksum byte after the payload).
module frame_uart_streamer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int FRAME_LEN = 614400
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] byte_count
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CPB_LAST    = CW'(CPB - 1);
  localparam logic [31:0]   FRAME_LEN_W = 32'(FRAME_LEN);

  typedef enum logic [2:0] {
    IDLE, SYNC0, SYNC1, FETCH, LOAD, SHIFT, CSUM, DONE
  } state_t;

  // Which byte the SHIFT state is currently serialising; decides where SHIFT goes next.
  typedef enum logic [1:0] {
    KIND_SYNC0, KIND_SYNC1, KIND_DATA, KIND_CSUM
  } kind_t;

  state_t         state;
  state_t         state_next;
  kind_t          kind;
  kind_t          load_kind;
  logic [7:0]     load_byte;
  logic [9:0]     frame_bits;
  logic [CW-1:0]  cycle_cnt;
  logic [3:0]     bit_idx;
  logic           shift_end;
  logic           last_payload;
`ifdef FRAME_UART_CSUM_EN
  logic [7:0]     csum;
`endif

  // Last cycle of the stop bit of the byte on the line.
  assign shift_end    = (state == SHIFT) && (cycle_cnt == CPB_LAST) && (bit_idx == 4'd9);
  // The payload byte now finishing is the final one of the frame.
  assign last_payload = (byte_count + 32'd1) >= FRAME_LEN_W;
  assign busy         = (state != IDLE);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic plus the single-cycle FIFO pop and frame-done strobes.
  always_comb begin
    state_next = state;
    fifo_rd_en = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (start) state_next = SYNC0;
      SYNC0, SYNC1, LOAD, CSUM: state_next = SHIFT;
      FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_en = rstn;
          state_next = LOAD;
        end
      end
      SHIFT: begin
        if (shift_end) begin
          case (kind)
            KIND_SYNC0: state_next = SYNC1;
            KIND_SYNC1: state_next = FETCH;
            KIND_DATA: begin
              if (!last_payload) state_next = FETCH;
`ifdef FRAME_UART_CSUM_EN
              else               state_next = CSUM;
`else
              else               state_next = DONE;
`endif
            end
            default: state_next = DONE;
          endcase
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Selects the byte (and its kind) that a loading state hands to the shifter.
  always_comb begin
    load_byte = fifo_rd_data;
    load_kind = KIND_DATA;
    case (state)
      SYNC0: begin load_byte = 8'hA5; load_kind = KIND_SYNC0; end
      SYNC1: begin load_byte = 8'h5A; load_kind = KIND_SYNC1; end
      CSUM: begin
`ifdef FRAME_UART_CSUM_EN
        load_byte = csum;
`else
        load_byte = 8'h00;
`endif
        load_kind = KIND_CSUM;
      end
      default: ;
    endcase
  end

  // Serialiser, bit timing, payload counter and checksum accumulation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      uart_tx    <= 1'b1;
      byte_count <= 32'd0;
      kind       <= KIND_SYNC0;
      frame_bits <= '1;
      cycle_cnt  <= '0;
      bit_idx    <= 4'd0;
`ifdef FRAME_UART_CSUM_EN
      csum       <= 8'h00;
`endif
    end else if (state == IDLE) begin
      if (start) begin
        byte_count <= 32'd0;
`ifdef FRAME_UART_CSUM_EN
        csum       <= 8'h00;
`endif
      end
    end else if (state inside {SYNC0, SYNC1, LOAD, CSUM}) begin
      frame_bits <= {1'b1, load_byte, 1'b0};
      uart_tx    <= 1'b0;
      kind       <= load_kind;
      cycle_cnt  <= '0;
      bit_idx    <= 4'd0;
`ifdef FRAME_UART_CSUM_EN
      if (state == LOAD) csum <= csum ^ fifo_rd_data;
`endif
    end else if (state == SHIFT) begin
      if (cycle_cnt == CPB_LAST) begin
        cycle_cnt <= '0;
        if (bit_idx == 4'd9) begin
          bit_idx <= 4'd0;
          uart_tx <= 1'b1;
          if (kind == KIND_DATA) byte_count <= byte_count + 32'd1;
        end else begin
          bit_idx    <= bit_idx + 4'd1;
          frame_bits <= {1'b1, frame_bits[9:1]};
          uart_tx    <= frame_bits[1];
        end
      end else begin
        cycle_cnt <= cycle_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_uart_streamer.sv
// tb_frame_uart_streamer: randomized frames against a queue-based model of the UART frame.
// Honours FRAME_UART_CSUM_EN the same way the design does.
module tb_frame_uart_streamer;

  localparam int CLK_HZ    = 8;
  localparam int BAUD      = 1;
  localparam int CPB       = CLK_HZ / BAUD;
  localparam int FRAME_LEN = 4;
`ifdef FRAME_UART_CSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;
  logic [31:0] byte_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_frame[$];
  logic [7:0] rx_q[$];
  int rd_count = 0;
  int done_count = 0;

  int         mon_idx = 0;
  int         mon_bit = 0;
  int         mon_cyc = 0;
  bit         mon_active = 1'b0;
  bit         mon_post = 1'b0;
  logic [9:0] mon_sh = '1;
  logic [7:0] mon_rx = 8'h00;

  frame_uart_streamer #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .uart_tx(uart_tx), .busy(busy), .frame_done(frame_done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Payload bytes the host should have counted once the n-th frame byte has finished.
  function automatic int exp_bc(input int n);
    if (n <= 2) return 0;
    if (n - 2 > FRAME_LEN) return FRAME_LEN;
    return n - 2;
  endfunction

  // FIFO model: pops on the strobe seen at the edge, data valid the following cycle.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_count++;
      check_bit("pop_while_empty", fifo_empty, 1'b0);
      if (fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Line decoder: checks every bit cycle against the expected frame and the gap cycle after each byte.
  always @(negedge clk) begin
    if (frame_done && rstn) done_count++;
    if (!rstn) begin
      mon_active = 1'b0;
      mon_post   = 1'b0;
      mon_idx    = 0;
    end else if (mon_post) begin
      mon_post = 1'b0;
      check_bit("gap_line_high", uart_tx, 1'b1);
      check_bit("frame_done_at_end", frame_done, mon_idx == exp_frame.size());
      check_val("byte_count_after_byte", byte_count, exp_bc(mon_idx));
      if (mon_idx >= exp_frame.size()) mon_idx = 0;
    end else begin
      if (!mon_active && uart_tx == 1'b0) begin
        mon_active = 1'b1;
        mon_bit    = 0;
        mon_cyc    = 0;
        if (mon_idx < exp_frame.size()) mon_sh = {1'b1, exp_frame[mon_idx], 1'b0};
        else begin
          check_val("frame_length", mon_idx + 1, exp_frame.size());
          mon_sh = '1;
        end
      end
      if (mon_active) begin
        check_bit("line_bit", uart_tx, mon_sh[0]);
        if (mon_bit >= 1 && mon_bit <= 8 && mon_cyc == CPB / 2) mon_rx = {uart_tx, mon_rx[7:1]};
        mon_cyc++;
        if (mon_cyc == CPB) begin
          mon_cyc = 0;
          mon_bit++;
          mon_sh = {1'b1, mon_sh[9:1]};
          if (mon_bit == 10) begin
            mon_active = 1'b0;
            rx_q.push_back(mon_rx);
            mon_idx++;
            mon_post = 1'b1;
          end
        end
      end
    end
  end

  // Builds the expected frame: header, payload (counting or random), XOR checksum when enabled.
  task automatic prepare_frame(input bit counting);
    logic [7:0] x;
    logic [7:0] p;
    x = 8'h00;
    exp_frame.delete();
    rx_q.delete();
    fifo_q.delete();
    fifo_empty = 1'b1;
    rd_count   = 0;
    done_count = 0;
    exp_frame.push_back(8'hA5);
    exp_frame.push_back(8'h5A);
    for (int i = 0; i < FRAME_LEN; i++) begin
      p = counting ? 8'(i + 1) : 8'($urandom_range(0, 255));
      exp_frame.push_back(p);
      x = x ^ p;
    end
    if (CSUM_BYTES == 1) exp_frame.push_back(x);
  endtask

  task automatic push_payload();
    for (int i = 0; i < FRAME_LEN; i++) fifo_q.push_back(exp_frame[i + 2]);
    fifo_empty = 1'b0;
  endtask

  task automatic apply_stimulus_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string name);
    int cyc;
    cyc = 0;
    while (rx_q.size() < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (rx_q.size() < n) check_val(name, rx_q.size(), n);
  endtask

  task automatic check_output_frame_end();
    int cyc;
    cyc = 0;
    while (done_count == 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    check_val("frame_done_pulses", done_count, 1);
    check_bit("busy_after_done", busy, 1'b0);
    check_val("rd_en_pulses", rd_count, FRAME_LEN);
    check_val("bytes_on_line", rx_q.size(), exp_frame.size());
    check_val("byte_count_final", byte_count, FRAME_LEN);
    for (int i = 0; i < exp_frame.size() && i < rx_q.size(); i++)
      check_val("rx_byte", 32'(rx_q[i]), 32'(exp_frame[i]));
  endtask

  task automatic check_reset_values(input string tag);
    check_bit({tag, "_uart_tx"}, uart_tx, 1'b1);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_fifo_rd_en"}, fifo_rd_en, 1'b0);
    check_bit({tag, "_frame_done"}, frame_done, 1'b0);
    check_val({tag, "_byte_count"}, byte_count, 32'd0);
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] lit_q[$];
    lit_q = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};

    // Reset for three cycles.
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: payload 01..04 preloaded, exact bit timing of 0xA5 from t+2.
    $display("[TB] frame with counting payload");
    prepare_frame(1'b1);
    push_payload();
    apply_stimulus_start();
    check_bit("busy_at_t1", busy, 1'b1);
    check_bit("line_idle_at_t1", uart_tx, 1'b1);
    pat = 10'b1_1010_0101_0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        check_bit("a5_bit_timing", uart_tx, pat[0]);
      end
      pat = {1'b1, pat[9:1]};
    end
    check_output_frame_end();
    for (int i = 0; i < 6 + CSUM_BYTES && i < rx_q.size(); i++)
      check_val("literal_byte", 32'(rx_q[i]), 32'(lit_q[i]));

    // Frame 2: FIFO empty for 50 cycles after the header.
    $display("[TB] frame with FIFO stall");
    prepare_frame(1'b0);
    apply_stimulus_start();
    wait_rx(2, "header_timeout");
    repeat (50) begin
      @(negedge clk);
      check_bit("stall_line_high", uart_tx, 1'b1);
      check_bit("stall_no_pop", fifo_rd_en, 1'b0);
    end
    @(negedge clk);
    push_payload();
    #1;
    check_bit("pop_after_refill", fifo_rd_en, 1'b1);
    check_output_frame_end();

    // Frame 3: start pulsed mid-frame is ignored; reset during payload byte 2.
    $display("[TB] frame aborted by reset");
    prepare_frame(1'b0);
    push_payload();
    apply_stimulus_start();
    wait_rx(1, "first_byte_timeout");
    repeat (10) @(negedge clk);
    apply_stimulus_start();
    wait_rx(3, "payload_timeout");
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_values("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 4 and a few random frames: full frames starting with the header.
    for (int f = 0; f < 4; f++) begin
      $display("[TB] random frame %0d", f);
      prepare_frame(1'b0);
      push_payload();
      repeat ($urandom_range(1, 5)) @(negedge clk);
      apply_stimulus_start();
      check_output_frame_end();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
